// File: rtl/led_array_pkg.sv
// -----------------------------------------------------------------------------
// led_array_pkg
// Shared types for the LED array controller.
//   mode_e      : per-channel display mode
//   cfg_state_e : configuration handshake FSM states
//   ch_cfg_t    : one channel's configuration record
// ch_cfg_t carries period/duty at fixed maximum widths so that a single
// packed type serves every parameterisation. Users zero-extend narrower
// values on the way in and compare at full width, so the upper bits stay 0.
// CNT_W must not exceed CNT_MAX_W, and PWM_W must not exceed PWM_MAX_W.
// -----------------------------------------------------------------------------
package led_array_pkg;

  localparam int CNT_MAX_W = 32;
  localparam int PWM_MAX_W = 16;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_PWM    = 2'd3
  } mode_e;

  typedef enum logic {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_e;

  typedef struct packed {
    logic                 src;     // 0 = val bus, 1 = AND of input buses
    mode_e                mode;
    logic [CNT_MAX_W-1:0] period;  // blink half-period minus 1
    logic [PWM_MAX_W-1:0] duty;    // PWM on-count
  } ch_cfg_t;

  localparam ch_cfg_t CH_CFG_RST = '{src: 1'b0, mode: MODE_OFF, period: '0, duty: '0};

  // A channel may take a new configuration only on a cycle where its
  // current mode is at a boundary, so the visible pattern never glitches.
  function automatic logic is_boundary(input mode_e mode, input logic blink_wrap,
                                       input logic pwm_last);
    logic b;
    b = 1'b1;
    if (mode == MODE_BLINK) b = blink_wrap;
    else if (mode == MODE_PWM) b = pwm_last;
    return b;
  endfunction

endpackage

// File: rtl/led_array_ctrl_channel.sv
// -----------------------------------------------------------------------------
// led_channel
// One LED channel: configuration register, blink counter/phase and the
// registered LED slice.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   i_pwm_cnt    : shared free-running PWM counter
//   i_apply      : load i_new_cfg this cycle (already used for this cycle's led)
//   i_new_cfg    : configuration to load on i_apply
//   i_src        : source value selected by the top using o_src_sel
//   o_src_sel    : source select in effect this cycle
//   o_boundary   : current mode is at a boundary this cycle
//   o_led        : registered LED slice
// -----------------------------------------------------------------------------
module led_channel
  import led_array_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16,
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] i_pwm_cnt,
  input  logic             i_apply,
  input  ch_cfg_t          i_new_cfg,
  input  logic [WIDTH-1:0] i_src,
  output logic             o_src_sel,
  output logic             o_boundary,
  output logic [WIDTH-1:0] o_led
);

  ch_cfg_t          r_cfg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic [WIDTH-1:0] r_led;

  logic                 w_wrap;
  logic                 w_eff_src;
  mode_e                w_eff_mode;
  logic [PWM_MAX_W-1:0] w_eff_duty;
  logic                 w_eff_phase;
  logic                 w_pwm_on;
  logic [WIDTH-1:0]     w_led_next;

  assign w_wrap     = (CNT_MAX_W'(r_cnt) == r_cfg.period);
  assign o_boundary = is_boundary(r_cfg.mode, w_wrap, &i_pwm_cnt);

  // On the apply cycle the new configuration and the post-apply phase (1)
  // already drive the output register.
  assign w_eff_src   = i_apply ? i_new_cfg.src  : r_cfg.src;
  assign w_eff_mode  = i_apply ? i_new_cfg.mode : r_cfg.mode;
  assign w_eff_duty  = i_apply ? i_new_cfg.duty : r_cfg.duty;
  assign w_eff_phase = i_apply | r_phase;
  assign o_src_sel   = w_eff_src;

  assign w_pwm_on = (PWM_MAX_W'(i_pwm_cnt) < w_eff_duty);

  always_comb begin
    w_led_next = '0;
    unique case (w_eff_mode)
      MODE_OFF:    w_led_next = '0;
      MODE_STATIC: w_led_next = i_src;
      MODE_BLINK:  w_led_next = i_src & {WIDTH{w_eff_phase}};
      MODE_PWM:    w_led_next = i_src & {WIDTH{w_pwm_on}};
      default:     w_led_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cfg   <= CH_CFG_RST;
      r_cnt   <= '0;
      r_phase <= 1'b1;
      r_led   <= '0;
    end else begin
      r_led <= w_led_next;
      if (i_apply) begin
        r_cfg   <= i_new_cfg;
        r_cnt   <= '0;
        r_phase <= 1'b1;
      end else if (w_wrap) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_array_ctrl.sv
// -----------------------------------------------------------------------------
// led_array_ctrl
// Drives NUM_CH LED channels of WIDTH bits. Each channel shows either the
// shared val bus or the AND of NUM_IN input buses, as OFF/STATIC/BLINK/PWM.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   in_bus            : NUM_IN buses, bus k at [k*WIDTH +: WIDTH]
//   val               : shared value bus
//   cfg_valid/ready   : configuration handshake
//   cfg_ch, cfg_src, cfg_mode, cfg_period, cfg_duty : configuration fields
//   cfg_err           : one-cycle pulse for an out-of-range cfg_ch
//   led               : channel c at [c*WIDTH +: WIDTH]
//   dbg_cfg_state     : configuration FSM state
// Handshake: a request transfers on a rising edge where cfg_valid=1 and
// cfg_ready=1. cfg_ready stays low from acceptance until the config has
// been applied; cfg_valid during that time is ignored and must be held by
// the requester.
// -----------------------------------------------------------------------------
module led_array_ctrl
  import led_array_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 4,
  parameter  int NUM_IN = 3,
  parameter  int CNT_W  = 16,
  parameter  int PWM_W  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [WIDTH-1:0]        val,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic                    cfg_src,
  input  logic [1:0]              cfg_mode,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [PWM_W-1:0]        cfg_duty,
  output logic                    cfg_err,
  output logic [NUM_CH*WIDTH-1:0] led,
  output cfg_state_e              dbg_cfg_state
);

  cfg_state_e       r_state;
  logic             r_cfg_ready;
  logic             r_cfg_err;
  logic [CH_W-1:0]  r_tgt_ch;
  ch_cfg_t          r_pend;
  logic [PWM_W-1:0] r_pwm_cnt;

  logic [WIDTH-1:0]  w_src_and;
  logic              w_ch_ok;
  logic [NUM_CH-1:0] w_bound;
  logic [NUM_CH-1:0] w_apply;
  logic [NUM_CH-1:0] w_src_sel;
  logic [WIDTH-1:0]  w_src [NUM_CH];
  logic [WIDTH-1:0]  w_led [NUM_CH];

  always_comb begin
    w_src_and = '1;
    for (int k = 0; k < NUM_IN; k++) begin
      w_src_and = w_src_and & in_bus[k*WIDTH +: WIDTH];
    end
  end

  assign w_ch_ok = (32'(cfg_ch) < NUM_CH);

  // Only the targeted channel, at its own boundary, takes the pending config.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_apply[c] = (r_state == CFG_PENDING) && (32'(r_tgt_ch) == c) && w_bound[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= CFG_IDLE;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
      r_tgt_ch    <= '0;
      r_pend      <= CH_CFG_RST;
    end else begin
      r_cfg_err <= 1'b0;
      unique case (r_state)
        CFG_IDLE: begin
          if (cfg_valid) begin
            if (w_ch_ok) begin
              r_tgt_ch    <= cfg_ch;
              r_pend      <= '{src:    cfg_src,
                               mode:   mode_e'(cfg_mode),
                               period: CNT_MAX_W'(cfg_period),
                               duty:   PWM_MAX_W'(cfg_duty)};
              r_state     <= CFG_PENDING;
              r_cfg_ready <= 1'b0;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        CFG_PENDING: begin
          if (|w_apply) begin
            r_state     <= CFG_IDLE;
            r_cfg_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= CFG_IDLE;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_src[c] = w_src_sel[c] ? w_src_and : val;

    led_channel #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .PWM_W (PWM_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_pwm_cnt  (r_pwm_cnt),
      .i_apply    (w_apply[c]),
      .i_new_cfg  (r_pend),
      .i_src      (w_src[c]),
      .o_src_sel  (w_src_sel[c]),
      .o_boundary (w_bound[c]),
      .o_led      (w_led[c])
    );

    assign led[c*WIDTH +: WIDTH] = w_led[c];
  end

  assign cfg_ready     = r_cfg_ready;
  assign cfg_err       = r_cfg_err;
  assign dbg_cfg_state = r_state;

endmodule

// File: tb/tb_led_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_array_ctrl
// Directed scenarios followed by randomized traffic, checked every cycle
// against a behavioural model. Blink output is derived from the number of
// cycles since the config was applied, PWM from the cycle count since reset.
// NUM_CH=5 so that cfg_ch values 5..7 are out of range.
// -----------------------------------------------------------------------------
module tb_led_array_ctrl;
  import led_array_pkg::*;

  localparam int NUM_CH = 5;
  localparam int WIDTH  = 4;
  localparam int NUM_IN = 3;
  localparam int CNT_W  = 16;
  localparam int PWM_W  = 8;
  localparam int CH_W   = 3;
  localparam int LED_W  = NUM_CH * WIDTH;
  localparam int BUDGET = 700;

  // ---------------- clock / reset / DUT ----------------
  logic                    clk;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [WIDTH-1:0]        val;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [CH_W-1:0]         cfg_ch;
  logic                    cfg_src;
  logic [1:0]              cfg_mode;
  logic [CNT_W-1:0]        cfg_period;
  logic [PWM_W-1:0]        cfg_duty;
  logic                    cfg_err;
  logic [LED_W-1:0]        led;
  cfg_state_e              dbg_cfg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  led_array_ctrl #(
    .NUM_CH (NUM_CH), .WIDTH (WIDTH), .NUM_IN (NUM_IN), .CNT_W (CNT_W), .PWM_W (PWM_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_bus        (in_bus),
    .val           (val),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_ch        (cfg_ch),
    .cfg_src       (cfg_src),
    .cfg_mode      (cfg_mode),
    .cfg_period    (cfg_period),
    .cfg_duty      (cfg_duty),
    .cfg_err       (cfg_err),
    .led           (led),
    .dbg_cfg_state (dbg_cfg_state)
  );

  // ---------------- scoreboard / model state ----------------
  typedef struct {
    bit src;
    int mode;    // 0 off, 1 static, 2 blink, 3 pwm
    int period;
    int duty;
  } mcfg_t;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [LED_W-1:0] exp_q[$];
  mcfg_t            m_cfg [NUM_CH];
  int               m_apply_cyc [NUM_CH];
  mcfg_t            m_pend;
  int               m_tgt;
  bit               m_idle;
  bit               m_err;
  int               m_cyc;
  bit               rand_on = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Channel output level for one edge; k = edges since the config was applied.
  function automatic bit m_on(input mcfg_t f, input int k, input int pwm);
    bit on;
    on = 1'b0;
    case (f.mode)
      1: on = 1'b1;
      2: on = (k == 0) || ((((k - 1) / (f.period + 1)) % 2) == 0);
      3: on = (pwm < f.duty);
      default: on = 1'b0;
    endcase
    return on;
  endfunction

  function automatic bit m_boundary(input int c);
    bit b;
    int k;
    b = 1'b1;
    k = m_cyc - m_apply_cyc[c];
    if (m_cfg[c].mode == 2) b = (k >= 1) && (((k - 1) % (m_cfg[c].period + 1)) == m_cfg[c].period);
    else if (m_cfg[c].mode == 3) b = ((m_cyc % 256) == 255);
    return b;
  endfunction

  task automatic model_edge();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] s;
    logic [LED_W-1:0] e;
    mcfg_t            f;
    int               app;
    int               k;
    bit               err_n;
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_cfg[c]       = '{src: 1'b0, mode: 0, period: 0, duty: 0};
        m_apply_cyc[c] = 0;
      end
      m_idle = 1'b1;
      m_err  = 1'b0;
      m_cyc  = 0;
      exp_q.push_back('0);
      return;
    end
    a = '1;
    for (int b = 0; b < NUM_IN; b++) a &= in_bus[b*WIDTH +: WIDTH];
    app = -1;
    if (!m_idle && m_boundary(m_tgt)) app = m_tgt;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      f = (c == app) ? m_pend : m_cfg[c];
      k = (c == app) ? 0 : (m_cyc - m_apply_cyc[c]);
      s = f.src ? a : val;
      if (m_on(f, k, m_cyc % 256)) e[c*WIDTH +: WIDTH] = s;
    end
    exp_q.push_back(e);
    err_n = 1'b0;
    if (m_idle) begin
      if (cfg_valid) begin
        if (int'(cfg_ch) >= NUM_CH) begin
          err_n = 1'b1;
        end else begin
          m_pend = '{src: cfg_src, mode: int'(cfg_mode), period: int'(cfg_period),
                     duty: int'(cfg_duty)};
          m_tgt  = int'(cfg_ch);
          m_idle = 1'b0;
        end
      end
    end else if (app >= 0) begin
      m_cfg[app]       = m_pend;
      m_apply_cyc[app] = m_cyc;
      m_idle           = 1'b1;
    end
    m_err = err_n;
    m_cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("led", led, exp_q.pop_front());
    check("cfg_ready", cfg_ready, m_idle);
    check("cfg_err", cfg_err, m_err);
    if (rand_on) begin
      val    = 4'($urandom_range(0, 15));
      in_bus = 12'($urandom);
    end
  endtask

  task automatic send_cfg(input int ch, input bit src, input int mode, input int period,
                          input int duty);
    bit done;
    done       = 1'b0;
    cfg_ch     = CH_W'(ch);
    cfg_src    = src;
    cfg_mode   = 2'(mode);
    cfg_period = CNT_W'(period);
    cfg_duty   = PWM_W'(duty);
    cfg_valid  = 1'b1;
    for (int i = 0; i < BUDGET && !done; i++) begin
      if (cfg_ready) done = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    if (!done) check("cfg_accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < BUDGET && !done; i++) begin
      if (cfg_ready) done = 1'b1;
      else tick();
    end
    if (!done) check("cfg_apply_timeout", 64'(done), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    rst_n      = 1'b0;
    in_bus     = '0;
    val        = '0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_src    = 1'b0;
    cfg_mode   = '0;
    cfg_period = '0;
    cfg_duty   = '0;
    m_idle     = 1'b1;
    m_tgt      = 0;
    m_pend     = '{src: 1'b0, mode: 0, period: 0, duty: 0};
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_led", led, '0);
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_err", cfg_err, 1'b0);

    // 1: ch1 STATIC from val
    val = 4'b1010;
    send_cfg(1, 1'b0, 1, 0, 0);
    wait_idle();
    tick();
    check("t1_ch1", led[7:4], 4'b1010);
    check("t1_others", led & ~20'h000F0, '0);

    // 2: ch0 STATIC from AND of buses
    in_bus = {4'b0110, 4'b1100, 4'b1111};
    send_cfg(0, 1'b1, 1, 0, 0);
    wait_idle();
    tick();
    check("t2_and", led[3:0], 4'b0100);
    in_bus[11:8] = 4'b1111;
    tick();
    check("t2_and_upd", led[3:0], 4'b1100);

    // 3: ch2 BLINK period 3, then mid-phase reconfigure
    val = 4'b1111;
    send_cfg(2, 1'b0, 2, 3, 0);
    wait_idle();
    for (int i = 0; i < 5; i++) tick();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (led[8]) cnt++;
    end
    check("t3_blink_on", 64'(cnt), 64'd8);
    tick();
    send_cfg(2, 1'b0, 1, 0, 0);
    wait_idle();
    tick();
    check("t3_restatic", led[11:8], 4'b1111);

    // 4: ch3 PWM duty 64
    val = 4'b0001;
    send_cfg(3, 1'b0, 3, 0, 64);
    wait_idle();
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (led[12]) cnt++;
    end
    check("t4_pwm_on", 64'(cnt), 64'd64);
    send_cfg(3, 1'b0, 3, 0, 128);
    wait_idle();

    // 5: out-of-range channel
    send_cfg(5, 1'b0, 1, 0, 0);
    check("t5_err", cfg_err, 1'b1);
    check("t5_ready", cfg_ready, 1'b1);
    tick();
    check("t5_err_clr", cfg_err, 1'b0);

    // 6: reset while a config is pending
    send_cfg(4, 1'b0, 2, 200, 0);
    wait_idle();
    send_cfg(4, 1'b0, 1, 0, 0);
    tick();
    check("t6_pending", cfg_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    check("t6_rst_led", led, '0);
    check("t6_rst_ready", cfg_ready, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    check("t6_never_applied", led[19:16], 4'b0000);

    // random traffic
    rand_on = 1'b1;
    for (int n = 0; n < 60; n++) begin
      send_cfg(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) wait_idle();
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) tick();
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end
    wait_idle();
    for (int i = 0; i < 20; i++) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
